// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction-in and result-out valid/ready channels of alu_issue_ctrl
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [1:0]  res_rd;
   logic        res_zero;
   modport master (output in_valid, in_instr, res_ready, input in_ready, res_valid, res_data, res_rd, res_zero);
   modport slave  (input in_valid, in_instr, res_ready, output in_ready, res_valid, res_data, res_rd, res_zero);
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller around an external 8-bit ALU, IDLE->EXEC->RESP per instruction.
// Optional ALU_ISSUE_PERF_EN adds a saturating completed-result counter on instr_cnt.
module alu_issue_ctrl #(
   parameter logic [7:0] RF_RESET_VAL = 8'h00,
   parameter bit         LI_SETS_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   alu_issue_if.slave bus,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_y,
   input  logic       alu_zero,
   output logic       zero_flag_q,
   output logic       busy
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [15:0] instr_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t      state_q, state_d;
   logic [7:0]  rf_q [4];
   logic [7:0]  alu_a_q, alu_b_q, imm_q, res_data_q, wdata;
   logic [2:0]  alu_op_q;
   logic [1:0]  rd_q;
   logic        li_q, res_zero_q, wzero, acc, done;
   logic        unused_bits;
   assign unused_bits = ^bus.in_instr[5:0];
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb begin
      acc = state_q == IDLE && bus.in_valid;
      done = state_q == RESP && bus.res_ready;
      state_d = acc ? EXEC : state_q == EXEC ? RESP : done ? IDLE : state_q;
      wdata = li_q ? imm_q : alu_y;
      wzero = li_q ? imm_q == 8'h00 : alu_zero;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < 4; i++) rf_q[i] <= RF_RESET_VAL;
         {alu_a_q, alu_b_q, alu_op_q, imm_q, res_data_q, rd_q} <= '0;
         {li_q, res_zero_q, zero_flag_q} <= '0;
      end else begin
         if (acc) begin
            li_q <= bus.in_instr[15];
            rd_q <= bus.in_instr[15] ? bus.in_instr[9:8] : bus.in_instr[11:10];
            imm_q <= bus.in_instr[7:0];
            if (!bus.in_instr[15]) begin
               alu_a_q <= rf_q[bus.in_instr[9:8]];
               alu_b_q <= rf_q[bus.in_instr[7:6]];
               alu_op_q <= bus.in_instr[14:12];
            end
         end
         // operands were captured at accept, so rd==rs writes cannot disturb them
         if (state_q == EXEC) begin
            rf_q[rd_q] <= wdata;
            res_data_q <= wdata;
            res_zero_q <= wzero;
            if (!li_q || LI_SETS_ZERO) zero_flag_q <= wzero;
         end
      end
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (done && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
   assign instr_cnt = cnt_q;
`endif
   assign bus.in_ready = state_q == IDLE;
   assign bus.res_valid = state_q == RESP;
   assign bus.res_data = res_data_q;
   assign bus.res_rd = rd_q;
   assign bus.res_zero = res_zero_q;
   assign alu_a = alu_a_q;
   assign alu_b = alu_b_q;
   assign alu_op = alu_op_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against alu_issue_ctrl with a bench-side ALU model.
module tb_alu_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] alu_a, alu_b, alu_y;
   logic [2:0] alu_op;
   logic       alu_zero, zero_flag_q, busy;
   int         n_cmp = 0;
   int         n_bad = 0;
   alu_issue_if bus();
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] instr_cnt;
`endif
   alu_issue_ctrl #(.RF_RESET_VAL(8'hA5), .LI_SETS_ZERO(1'b0)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_zero(alu_zero),
      .zero_flag_q(zero_flag_q), .busy(busy)
`ifdef ALU_ISSUE_PERF_EN
      , .instr_cnt(instr_cnt)
`endif
   );
   always #5 clk = ~clk;
   // bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A
   assign alu_y = alu_op == 3'd0 ? alu_a + alu_b : alu_op == 3'd1 ? alu_a - alu_b :
                  alu_op == 3'd2 ? alu_a & alu_b : alu_op == 3'd3 ? alu_a | alu_b :
                  alu_op == 3'd4 ? alu_a ^ alu_b : alu_a;
   assign alu_zero = alu_y == 8'h00;
   function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
      return {1'b1, 5'b0, rd, imm};
   endfunction
   function automatic logic [15:0] alu(input logic [2:0] op, input logic [1:0] rd, rs1, rs2);
      return {1'b0, op, rd, rs1, rs2, 6'b0};
   endfunction
   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // accept, pass EXEC, return sitting in the first RESP cycle
   task automatic issue(input logic [15:0] ins);
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      tick();
      bus.in_valid = 1'b0;
      tick();
   endtask
   task automatic result(input string tag, input logic [7:0] d, input logic [1:0] rd, input logic z);
      chk({tag, ".valid"}, {15'b0, bus.res_valid}, 16'd1);
      chk({tag, ".data"}, {8'b0, bus.res_data}, {8'b0, d});
      chk({tag, ".rd"}, {14'b0, bus.res_rd}, {14'b0, rd});
      chk({tag, ".zero"}, {15'b0, bus.res_zero}, {15'b0, z});
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.res_ready = 1'b1;
      tick();
      tick();
      chk("rst.in_ready", {15'b0, bus.in_ready}, 16'd1);
      chk("rst.res_valid", {15'b0, bus.res_valid}, 16'd0);
      chk("rst.busy", {15'b0, busy}, 16'd0);
      chk("rst.alu_a", {8'b0, alu_a}, 16'd0);
      chk("rst.res_data", {8'b0, bus.res_data}, 16'd0);
      chk("rst.zflag", {15'b0, zero_flag_q}, 16'd0);
      rst = 1'b0;
      tick();
      issue(li(2'd1, 8'h05));
      result("li_r1", 8'h05, 2'd1, 1'b0);
      chk("li_r1.busy", {15'b0, busy}, 16'd1);
      chk("li_r1.in_ready", {15'b0, bus.in_ready}, 16'd0);
      tick();
      chk("idle.in_ready", {15'b0, bus.in_ready}, 16'd1);
      issue(li(2'd2, 8'h03));
      tick();
      issue(alu(3'd0, 2'd3, 2'd1, 2'd2));
      result("add8", 8'h08, 2'd3, 1'b0);
      chk("add8.alu_a", {8'b0, alu_a}, 16'h0005);
      chk("add8.alu_b", {8'b0, alu_b}, 16'h0003);
      tick();
      issue(alu(3'd3, 2'd0, 2'd3, 2'd3));
      result("rf3_read", 8'h08, 2'd0, 1'b0);
      tick();
      issue(alu(3'd1, 2'd0, 2'd1, 2'd1));
      result("sub0", 8'h00, 2'd0, 1'b1);
      chk("sub0.zflag", {15'b0, zero_flag_q}, 16'd1);
      tick();
      issue(li(2'd2, 8'h00));
      result("li0", 8'h00, 2'd2, 1'b1);
      chk("li0.zflag_held1", {15'b0, zero_flag_q}, 16'd1);
      tick();
      issue(alu(3'd0, 2'd0, 2'd1, 2'd1));
      result("add_a", 8'h0A, 2'd0, 1'b0);
      chk("add_a.zflag", {15'b0, zero_flag_q}, 16'd0);
      tick();
      issue(li(2'd2, 8'h00));
      chk("li0b.zflag_held0", {15'b0, zero_flag_q}, 16'd0);
      tick();
      issue(li(2'd1, 8'hFF));
      tick();
      issue(li(2'd2, 8'h02));
      tick();
      issue(alu(3'd0, 2'd3, 2'd1, 2'd2));
      result("wrap", 8'h01, 2'd3, 1'b0);
      tick();
      bus.res_ready = 1'b0;
      issue(li(2'd1, 8'h07));
      bus.in_valid = 1'b1;
      bus.in_instr = li(2'd0, 8'h33);
      for (int i = 0; i < 5; i++) begin
         chk("stall.valid", {15'b0, bus.res_valid}, 16'd1);
         chk("stall.data", {8'b0, bus.res_data}, 16'h0007);
         chk("stall.in_ready", {15'b0, bus.in_ready}, 16'd0);
         tick();
      end
      bus.res_ready = 1'b1;
      bus.in_instr = li(2'd2, 8'h09);
      tick();
      chk("resume.in_ready", {15'b0, bus.in_ready}, 16'd1);
      chk("resume.busy", {15'b0, busy}, 16'd0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      result("resume", 8'h09, 2'd2, 1'b0);
      tick();
      bus.in_valid = 1'b1;
      bus.in_instr = alu(3'd0, 2'd3, 2'd1, 2'd2);
      tick();
      bus.in_valid = 1'b0;
      chk("abort.busy_exec", {15'b0, busy}, 16'd1);
      rst = 1'b1;
      #1;
      chk("abort.res_valid", {15'b0, bus.res_valid}, 16'd0);
      chk("abort.busy", {15'b0, busy}, 16'd0);
      chk("abort.alu_a", {8'b0, alu_a}, 16'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort.in_ready", {15'b0, bus.in_ready}, 16'd1);
      issue(alu(3'd3, 2'd0, 2'd3, 2'd3));
      result("abort.rf3", 8'hA5, 2'd0, 1'b0);
      chk("abort.rf3_a", {8'b0, alu_a}, 16'h00A5);
      tick();
`ifdef ALU_ISSUE_PERF_EN
      chk("perf.one", instr_cnt, 16'd1);
      issue(li(2'd0, 8'h01));
      tick();
      issue(li(2'd0, 8'h02));
      tick();
      chk("perf.three", instr_cnt, 16'd3);
      force dut.cnt_q = 16'hFFFE;
      #1;
      release dut.cnt_q;
      issue(li(2'd0, 8'h03));
      tick();
      chk("perf.top", instr_cnt, 16'hFFFF);
      issue(li(2'd0, 8'h04));
      tick();
      chk("perf.sat", instr_cnt, 16'hFFFF);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
